// File: rtl/core_pkg.sv
// Shared write-back definitions: producer ids and producer count.
// Index order of every per-source vector follows wb_src_e.
package core_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_DIV  = 2'd2
   } wb_src_e;

   localparam int NUM_WB_SRC = 3;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry result hold register with a saturating starvation age.
// The slot can be refilled on the same edge its held result is granted.
module wb_hold_slot
   import core_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_data,
   input  logic            grant,
   input  logic            run,
   output logic            hold_v,
   output logic [4:0]      hold_rd,
   output logic [XLEN-1:0] hold_data,
   output logic            starved
);

   localparam int AW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

   logic [AW-1:0] age;

   assign in_ready = !hold_v || grant;
   assign starved  = hold_v && (age == AGE_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_v    <= 1'b0;
         hold_rd   <= '0;
         hold_data <= '0;
         age       <= '0;
      end else if (in_valid && in_ready) begin
         hold_v    <= 1'b1;
         hold_rd   <= in_rd;
         hold_data <= in_data;
         age       <= '0;
      end else if (grant) begin
         hold_v <= 1'b0;
         age    <= '0;
      end else if (!hold_v) begin
         age <= '0;
      end else if (run && (age != AGE_MAX)) begin
         age <= age + 1'b1;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter for ALU, load and divide results.
// Fixed priority LOAD > DIV > ALU, overridden by slots that have aged out.
module wb_arbiter
   import core_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            run,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic            div_valid,
   output logic            div_ready_o,
   input  logic [4:0]      div_rd,
   input  logic [XLEN-1:0] div_data,
   output logic            reg_we,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] wdata,
   output logic [1:0]      grant_src,
   output logic [2:0]      pending
);

   logic [NUM_WB_SRC-1:0] v_in;
   logic [NUM_WB_SRC-1:0] rdy;
   logic [NUM_WB_SRC-1:0] hv;
   logic [NUM_WB_SRC-1:0] stv;
   logic [NUM_WB_SRC-1:0] gnt;
   logic [NUM_WB_SRC-1:0] cand;
   logic [4:0]            rd_in [NUM_WB_SRC];
   logic [XLEN-1:0]       dat_in[NUM_WB_SRC];
   logic [4:0]            hrd   [NUM_WB_SRC];
   logic [XLEN-1:0]       hdat  [NUM_WB_SRC];
   wb_src_e               sel;
   logic                  any;

   assign v_in = {div_valid, ld_valid, alu_valid};

   assign rd_in[WB_ALU]   = alu_rd;
   assign rd_in[WB_LOAD]  = ld_rd;
   assign rd_in[WB_DIV]   = div_rd;
   assign dat_in[WB_ALU]  = alu_data;
   assign dat_in[WB_LOAD] = ld_data;
   assign dat_in[WB_DIV]  = div_data;

   for (genvar i = 0; i < NUM_WB_SRC; i++) begin : g_slot
      wb_hold_slot #(
         .XLEN        (XLEN),
         .STARVE_LIMIT(STARVE_LIMIT)
      ) u_slot (
         .clk      (clk),
         .reset_n  (reset_n),
         .in_valid (v_in[i]),
         .in_ready (rdy[i]),
         .in_rd    (rd_in[i]),
         .in_data  (dat_in[i]),
         .grant    (gnt[i]),
         .run      (run),
         .hold_v   (hv[i]),
         .hold_rd  (hrd[i]),
         .hold_data(hdat[i]),
         .starved  (stv[i])
      );
   end

   assign alu_ready   = rdy[WB_ALU];
   assign ld_ready    = rdy[WB_LOAD];
   assign div_ready_o = rdy[WB_DIV];
   assign pending     = hv;

   // Aged-out slots form the candidate set whenever any exist.
   assign cand = (|stv) ? stv : hv;

   always_comb begin
      sel = WB_ALU;
      any = 1'b0;
      gnt = '0;
      if (run) begin
         priority case (1'b1)
            cand[WB_LOAD]: begin sel = WB_LOAD; any = 1'b1; end
            cand[WB_DIV]:  begin sel = WB_DIV;  any = 1'b1; end
            cand[WB_ALU]:  begin sel = WB_ALU;  any = 1'b1; end
            default:       any = 1'b0;
         endcase
      end
      gnt[sel] = any;
   end

   // x0 writes are consumed from the slot but never reach the file.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_we    <= 1'b0;
         rd        <= '0;
         wdata     <= '0;
         grant_src <= '0;
      end else if (any) begin
         reg_we    <= (hrd[sel] != 5'd0);
         rd        <= hrd[sel];
         wdata     <= hdat[sel];
         grant_src <= sel;
      end else begin
         reg_we <= 1'b0;
      end
   end

endmodule
